image_capture: RTL and testbench

IMAGE_CAPTURE -- requirements
Module: image_capture

---
 rtl/image_capture_pkg.sv | 26 ++
 rtl/image_capture_if.sv | 32 +++
 rtl/image_capture_pixel_binarizer.sv | 14 +
 rtl/image_capture.sv | 172 +++++++++++++++++
 tb/tb_image_capture.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/image_capture_pkg.sv
// Shared definitions for the image capture block.
//   LENGTH, WIDTH    : frame geometry (rows x columns) shared with the classifier
//   ROW_W, COL_W     : counter widths derived from the geometry
//   ROW_LAST/COL_LAST: last row/column index, typed to the counter widths
//   capture_state_t  : capture FSM states
//   frame_t          : binarized frame, frame[i][j] is row i, column j
package image_capture_pkg;

  localparam int LENGTH = 4;
  localparam int WIDTH  = 4;

  localparam int ROW_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PUBLISH = 2'd2
  } capture_state_t;

  typedef logic [LENGTH-1:0][WIDTH-1:0] frame_t;

endpackage

// File: rtl/image_capture_if.sv
// Pixel stream interface into the image capture block.
//   sof       : start-of-frame, qualifies the first pixel of a frame
//   pix_valid : pixel present on pix_data
//   pix_data  : unsigned grayscale pixel, raster order
//   threshold : binarization threshold, sampled with each accepted pixel
//   pix_ready : sink accepts a pixel this cycle
// Modports: master = pixel source, slave = image_capture.
interface image_capture_if #(
  parameter int PIX_W = 8
) ();
  logic             sof;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic [PIX_W-1:0] threshold;
  logic             pix_ready;

  modport master (
    output sof,
    output pix_valid,
    output pix_data,
    output threshold,
    input  pix_ready
  );

  modport slave (
    input  sof,
    input  pix_valid,
    input  pix_data,
    input  threshold,
    output pix_ready
  );
endinterface

// File: rtl/image_capture_pixel_binarizer.sv
// pixel_binarizer: combinational unsigned compare of one pixel against a
// threshold.
//   pix_data  : input pixel (PIX_W bits, unsigned)
//   threshold : input threshold (PIX_W bits, unsigned)
//   bin       : output, 1 when pix_data >= threshold
module pixel_binarizer #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] pix_data,
  input  logic [PIX_W-1:0] threshold,
  output logic             bin
);
  assign bin = (pix_data >= threshold);
endmodule

// File: rtl/image_capture.sv
// image_capture: collects a LENGTH x WIDTH binarized frame from a raster pixel
// stream and publishes it to the classifier with an init_out strobe.
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   pix       : pixel stream (image_capture_if.slave)
//   image     : last completed binarized frame, image[i][j] = row i, column j
//   init_out  : frame-ready strobe, high HOLD_CYC cycles per completed frame
//   busy      : high while a frame is partially captured
//   frame_err : one-cycle pulse after a frame is truncated by a new sof
// Optional feature: define CAPTURE_FRAME_CHECK_EN to enable frame_err;
// otherwise frame_err is tied to 0 and restart behaviour is unchanged.
module image_capture
  import image_capture_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  image_capture_if.slave          pix,
  output frame_t                  image,
  output logic                    init_out,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  capture_state_t     state_reg, state_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic [COL_W-1:0]   col_reg, col_next;
  frame_t             shadow_reg, shadow_next;
  frame_t             image_reg, image_next;
  logic               init_reg, init_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;

  logic               pix_bit;
  logic               accept;
  logic               wr_en;
  logic [ROW_W-1:0]   wr_row;
  logic [COL_W-1:0]   wr_col;

  pixel_binarizer #(
    .PIX_W(PIX_W)
  ) u_binarizer (
    .pix_data (pix.pix_data),
    .threshold(pix.threshold),
    .bin      (pix_bit)
  );

  assign pix.pix_ready = (state_reg != PUBLISH);
  assign accept        = pix.pix_valid && pix.pix_ready;

`ifdef CAPTURE_FRAME_CHECK_EN
  logic err_reg, err_next;
`endif

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    shadow_next = shadow_reg;
    image_next  = image_reg;
    init_next   = init_reg;
    hold_next   = hold_reg;
    wr_en       = 1'b0;
    wr_row      = '0;
    wr_col      = '0;
`ifdef CAPTURE_FRAME_CHECK_EN
    err_next    = 1'b0;
`endif

    // Pick the shadow position for an accepted pixel. A sof pixel always
    // lands at (0,0), whether it starts a frame or restarts one.
    case (state_reg)
      IDLE: begin
        if (accept && pix.sof) begin
          wr_en = 1'b1;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pix.sof) begin
`ifdef CAPTURE_FRAME_CHECK_EN
            err_next = 1'b1;
`endif
          end else begin
            wr_row = row_reg;
            wr_col = col_reg;
          end
        end
      end
      PUBLISH: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = IDLE;
          init_next  = 1'b0;
          hold_next  = '0;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        init_next  = 1'b0;
      end
    endcase

    // Store the pixel, then either advance the raster position or, on the
    // final pixel, publish the frame including the bit just written. A 1x1
    // frame completes here straight from IDLE.
    if (wr_en) begin
      shadow_next[wr_row][wr_col] = pix_bit;
      if (wr_row == ROW_LAST && wr_col == COL_LAST) begin
        image_next = shadow_next;
        init_next  = 1'b1;
        hold_next  = '0;
        state_next = PUBLISH;
        row_next   = '0;
        col_next   = '0;
      end else begin
        state_next = CAPTURE;
        if (wr_col == COL_LAST) begin
          col_next = '0;
          row_next = wr_row + 1'b1;
        end else begin
          col_next = wr_col + 1'b1;
          row_next = wr_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      row_reg    <= '0;
      col_reg    <= '0;
      shadow_reg <= '0;
      image_reg  <= '0;
      init_reg   <= 1'b0;
      hold_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      shadow_reg <= shadow_next;
      image_reg  <= image_next;
      init_reg   <= init_next;
      hold_reg   <= hold_next;
    end
  end

`ifdef CAPTURE_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end
  assign frame_err = err_reg;
`else
  assign frame_err = 1'b0;
`endif

  assign image    = image_reg;
  assign init_out = init_reg;
  assign busy     = (state_reg == CAPTURE);

endmodule

// File: tb/tb_image_capture.sv
// Self-checking bench for image_capture. A queue-based frame model tracks the
// expected image, strobe, busy and frame_err; each scenario task compares the
// DUT against it (or against constants) one cycle at a time.
module tb_image_capture;
  import image_capture_pkg::*;

  localparam int PIX_W = 8;
  localparam int HOLD  = 2;
  localparam int N     = LENGTH * WIDTH;

  logic   clk = 1'b0;
  logic   rst;
  frame_t image;
  logic   init_out, busy, frame_err;

  always #5 clk = ~clk;

  image_capture_if #(.PIX_W(PIX_W)) pix ();

  image_capture #(
    .PIX_W   (PIX_W),
    .HOLD_CYC(HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix      (pix),
    .image    (image),
    .init_out (init_out),
    .busy     (busy),
    .frame_err(frame_err)
  );

  // Reference model state
  frame_t m_image;
  bit     m_q[$];
  bit     m_cap;
  int     m_hold;
  bit     m_err;
  frame_t checker_img;

  int total = 0;
  int bad   = 0;

  // Drive one cycle, advance the model on the edge, sample 1 ns later.
  task automatic step(input bit s, input bit v, input logic [7:0] d,
                      input logic [7:0] t, input bit r = 1'b0);
    bit b;
    bit restart;
    rst = r; pix.sof = s; pix.pix_valid = v; pix.pix_data = d; pix.threshold = t;
    @(posedge clk);
    restart = 1'b0;
    if (r) begin
      m_q.delete(); m_cap = 1'b0; m_hold = 0; m_image = '0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (v) begin
      b = (d >= t);
      if (s) begin
        restart = m_cap;
        m_q.delete();
        m_q.push_back(b);
        m_cap = 1'b1;
      end else if (m_cap) begin
        m_q.push_back(b);
      end
      if (m_cap && m_q.size() == N) begin
        for (int k = 0; k < N; k++) m_image[k / WIDTH][k % WIDTH] = m_q[k];
        m_hold = HOLD;
        m_cap  = 1'b0;
        m_q.delete();
      end
    end
`ifdef CAPTURE_FRAME_CHECK_EN
    m_err = restart;
`else
    m_err = 1'b0;
`endif
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    total++; if (image !== frame_t'(0)) begin bad++; $display("FAIL reset_image got=%h want=0", image); end
    total++; if (init_out !== 1'b0) begin bad++; $display("FAIL reset_init got=%b want=0", init_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
    total++; if (pix.pix_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", pix.pix_ready); end
    $display("reset: image=%h ready=%b", image, pix.pix_ready);
  endtask

  task automatic test_threshold();
    step(1'b1, 1'b1, 8'h80, 8'h80);
    step(1'b0, 1'b1, 8'h7F, 8'h80);
    for (int k = 2; k < N; k++) step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    total++; if (image[0][0] !== 1'b1) begin bad++; $display("FAIL thr_eq got=%b want=1", image[0][0]); end
    total++; if (image[0][1] !== 1'b0) begin bad++; $display("FAIL thr_below got=%b want=0", image[0][1]); end
    total++; if (image !== m_image) begin bad++; $display("FAIL thr_image got=%h want=%h", image, m_image); end
    total++; if (init_out !== 1'b1) begin bad++; $display("FAIL thr_init got=%b want=1", init_out); end
    $display("threshold: image=%h", image);
    idle(HOLD);
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < N; k++) begin
      checker_img[k / WIDTH][k % WIDTH] = (k % 2 == 0);
      step(k == 0, 1'b1, (k % 2 == 0) ? 8'hFF : 8'h00, 8'h80);
      if (k < N - 1) begin
        total++; if (init_out !== 1'b0) begin bad++; $display("FAIL full_early_init k=%0d got=%b want=0", k, init_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy k=%0d got=%b want=1", k, busy); end
      end
    end
    total++; if (image !== checker_img) begin bad++; $display("FAIL full_image got=%h want=%h", image, checker_img); end
    for (int c = 0; c < HOLD; c++) begin
      total++; if (init_out !== 1'b1) begin bad++; $display("FAIL full_init c=%0d got=%b want=1", c, init_out); end
      total++; if (pix.pix_ready !== 1'b0) begin bad++; $display("FAIL full_ready c=%0d got=%b want=0", c, pix.pix_ready); end
      step(1'b1, 1'b1, 8'h00, 8'hFF);   // offered while not ready: must be dropped
    end
    total++; if (init_out !== 1'b0) begin bad++; $display("FAIL full_init_end got=%b want=0", init_out); end
    total++; if (pix.pix_ready !== 1'b1) begin bad++; $display("FAIL full_ready_end got=%b want=1", pix.pix_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%b want=0", busy); end
    total++; if (image !== checker_img) begin bad++; $display("FAIL full_hold_image got=%h want=%h", image, checker_img); end
    $display("full_frame: image=%h", image);
  endtask

  task automatic test_pre_sof();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'($urandom), 8'h00);
      total++; if (init_out !== 1'b0) begin bad++; $display("FAIL presof_init k=%0d got=%b want=0", k, init_out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL presof_busy k=%0d got=%b want=0", k, busy); end
    end
    total++; if (image !== checker_img) begin bad++; $display("FAIL presof_image got=%h want=%h", image, checker_img); end
    $display("pre_sof: image=%h", image);
  endtask

  task automatic test_restart();
    for (int k = 0; k < 5; k++) step(k == 0, 1'b1, 8'($urandom), 8'h80);
    step(1'b1, 1'b1, 8'($urandom), 8'h80);
`ifdef CAPTURE_FRAME_CHECK_EN
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL restart_err got=%b want=1", frame_err); end
`else
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL restart_err got=%b want=0", frame_err); end
`endif
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy); end
    for (int k = 1; k < N; k++) begin
      step(1'b0, 1'b1, 8'($urandom), 8'h80);
      if (k == 1) begin
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL restart_err_clear got=%b want=0", frame_err); end
      end
      if (k < N - 1) begin
        total++; if (init_out !== 1'b0) begin bad++; $display("FAIL restart_early k=%0d got=%b want=0", k, init_out); end
      end
    end
    total++; if (init_out !== 1'b1) begin bad++; $display("FAIL restart_init got=%b want=1", init_out); end
    total++; if (image !== m_image) begin bad++; $display("FAIL restart_image got=%h want=%h", image, m_image); end
    $display("restart: image=%h", image);
    idle(HOLD);
  endtask

  task automatic test_stalls();
    int p = 0;
    for (int cyc = 0; cyc < 4 * N && p < N; cyc++) begin
      bit v = (cyc % 2 == 0);
      step(v && p == 0, v, (p % 2 == 0) ? 8'hFF : 8'h00, 8'h80);
      if (v) p++;
      if (p < N) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy p=%0d got=%b want=1", p, busy); end
      end
    end
    total++; if (init_out !== 1'b1) begin bad++; $display("FAIL stall_init got=%b want=1", init_out); end
    total++; if (image !== checker_img) begin bad++; $display("FAIL stall_image got=%h want=%h", image, checker_img); end
    $display("stalls: image=%h", image);
    idle(HOLD);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) step(k == 0, 1'b1, 8'($urandom), 8'h80);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
    total++; if (image !== frame_t'(0)) begin bad++; $display("FAIL rmid_image got=%h want=0", image); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 8'($urandom), 8'h80);
      total++; if (init_out !== 1'b0) begin bad++; $display("FAIL rmid_init k=%0d got=%b want=0", k, init_out); end
    end
    for (int k = 0; k < N; k++) step(k == 0, 1'b1, 8'($urandom), 8'h80);
    total++; if (init_out !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b want=1", init_out); end
    total++; if (image !== m_image) begin bad++; $display("FAIL rmid_frame got=%h want=%h", image, m_image); end
    $display("reset_mid: image=%h", image);
    idle(HOLD);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom_range(64, 192)), $urandom_range(0, 149) == 0);
      total++; if (init_out !== (m_hold > 0)) begin bad++; $display("FAIL rnd_init i=%0d got=%b want=%b", i, init_out, m_hold > 0); end
      total++; if (pix.pix_ready !== (m_hold == 0)) begin bad++; $display("FAIL rnd_ready i=%0d got=%b want=%b", i, pix.pix_ready, m_hold == 0); end
      total++; if (busy !== m_cap) begin bad++; $display("FAIL rnd_busy i=%0d got=%b want=%b", i, busy, m_cap); end
      total++; if (frame_err !== m_err) begin bad++; $display("FAIL rnd_err i=%0d got=%b want=%b", i, frame_err, m_err); end
      total++; if (image !== m_image) begin bad++; $display("FAIL rnd_image i=%0d got=%h want=%h", i, image, m_image); end
    end
    $display("random: image=%h", image);
  endtask

  initial begin
    rst = 1'b1; pix.sof = 1'b0; pix.pix_valid = 1'b0; pix.pix_data = '0; pix.threshold = '0;
    m_image = '0; m_cap = 1'b0; m_hold = 0; m_err = 1'b0; checker_img = '0;
    test_reset();
    test_threshold();
    test_full_frame();
    test_pre_sof();
    test_restart();
    test_stalls();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
